// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_t;

    localparam int unsigned BCD_ADJ_THRESH = 5;
    localparam int unsigned BCD_ADJ_ADD    = 3;

    // True when 10**digits >= 2**width, evaluated without overflowing for large digit counts.
    function automatic bit digits_cover_width(input int unsigned width, input int unsigned digits);
        longint unsigned cap  = 64'd1;
        longint unsigned need = 64'd1 << width;
        for (int unsigned i = 0; i < digits; i++) begin
            if (cap >= need) break;
            cap = cap * 64'd10;
        end
        return cap >= need;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit adjust: add 3 to a BCD digit that is 5 or more.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t in,
    output bcd_digit_t out
);

    assign out = (in >= 4'(BCD_ADJ_THRESH)) ? in + 4'(BCD_ADJ_ADD) : in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock,
// with a start/busy/done handshake and a held result register.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CAT_W = BCD_W + WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 4 || WIDTH > 20) begin : g_width_check
        $error("bin_to_bcd_seq: WIDTH=%0d outside 4..20", WIDTH);
    end
    if (!digits_cover_width(WIDTH, DIGITS)) begin : g_digits_check
        $error("bin_to_bcd_seq: DIGITS=%0d cannot hold 2**%0d-1", DIGITS, WIDTH);
    end

    conv_state_t        state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [BCD_W-1:0]   adj;
    logic [CAT_W-1:0]   shifted;

    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_adj
        bcd_add3_digit u_adj (
            .in  (scratch_q[4*i +: 4]),
            .out (adj[4*i +: 4])
        );
    end

    // One iteration: adjusted scratch and the binary operand shift left together.
    assign shifted = {adj, shift_q} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[CAT_W-1:WIDTH];
                shift_d   = shifted[WIDTH-1:0];
                cnt_d     = cnt_q - CNT_W'(1);
                // Last iteration publishes the result in the same edge.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = shifted[CAT_W-1:WIDTH];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: 8-bit/3-digit and 16-bit/5-digit instances
// checked against a decimal-division reference model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  bin8;
    logic [15:0] bin16;
    logic        busy8, done8, busy16, done16;
    logic [11:0] bcd8;
    logic [19:0] bcd16;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .bin_in(bin8),
        .busy(busy8), .done(done8), .bcd_out(bcd8)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .bin_in(bin16),
        .busy(busy16), .done(done16), .bcd_out(bcd16)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Decimal digits by repeated division.
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r = '0;
        int unsigned x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Move to the input-drive point of the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the drive phase of cycle 0; returns at the falling edge of the done cycle.
    task automatic run_conv(input bit wide, input int unsigned v, input bit noise,
                            output int done_cyc, output logic [19:0] res, output bit busy_ok);
        busy_ok  = 1'b1;
        done_cyc = -1;
        res      = '0;
        if (wide) begin start16 = 1'b1; bin16 = 16'(v); end
        else      begin start8  = 1'b1; bin8  = 8'(v);  end
        tick();
        start8  = 1'b0;
        start16 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (noise) begin bin8 = 8'($urandom); bin16 = 16'($urandom); end
            @(negedge clk);
            if (wide ? done16 : done8) begin
                done_cyc = c;
                res      = wide ? bcd16 : {8'h0, bcd8};
                if (wide ? busy16 : busy8) busy_ok = 1'b0;
                break;
            end
            if (!(wide ? busy16 : busy8)) busy_ok = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b1; start16 = 1'b1; bin8 = 8'hFF; bin16 = 16'hFFFF;
        tick(); tick(); tick();
        @(negedge clk);
        vectors++; if (busy8 !== 1'b0)    begin miscompares++; $display("FAIL reset_busy8: got %b want 0", busy8); end
        vectors++; if (done8 !== 1'b0)    begin miscompares++; $display("FAIL reset_done8: got %b want 0", done8); end
        vectors++; if (bcd8 !== 12'h000)  begin miscompares++; $display("FAIL reset_bcd8: got %h want 000", bcd8); end
        vectors++; if (busy16 !== 1'b0)   begin miscompares++; $display("FAIL reset_busy16: got %b want 0", busy16); end
        vectors++; if (bcd16 !== 20'h0)   begin miscompares++; $display("FAIL reset_bcd16: got %h want 00000", bcd16); end
        tick();
        rst = 1'b0; start8 = 1'b0; start16 = 1'b0;
        tick();
        @(negedge clk);
        vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL idle_busy8: got %b want 0", busy8); end
        tick();
    endtask

    task automatic test_latency();
        int cyc; logic [19:0] res; bit bok;
        run_conv(1'b0, 0, 1'b1, cyc, res, bok);
        vectors++; if (cyc !== 9)       begin miscompares++; $display("FAIL latency8: done cycle %0d want 9", cyc); end
        vectors++; if (bok !== 1'b1)    begin miscompares++; $display("FAIL busy_window8: busy not high exactly in cycles 1..8"); end
        vectors++; if (res !== 20'h0)   begin miscompares++; $display("FAIL zero8: got %h want 000", res[11:0]); end
        tick();
        @(negedge clk);
        vectors++; if (done8 !== 1'b0)  begin miscompares++; $display("FAIL done_pulse8: done still %b one cycle later, want 0", done8); end
        tick();
    endtask

    task automatic test_directed();
        int unsigned vals [3] = '{255, 15, 99};
        logic [19:0] exps [3] = '{20'h255, 20'h015, 20'h099};
        int cyc; logic [19:0] res; bit bok;
        for (int i = 0; i < 3; i++) begin
            run_conv(1'b0, vals[i], 1'b1, cyc, res, bok);
            vectors++;
            if (res !== exps[i] || cyc !== 9) begin
                miscompares++;
                $display("FAIL directed_%0d: got %h at cycle %0d want %h at cycle 9", vals[i], res[11:0], cyc, exps[i][11:0]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int dq[$];
        bit hold_ok = 1'b1;
        start8 = 1'b1; bin8 = 8'd100;
        tick();
        bin8 = 8'd200;
        for (int c = 1; c <= 25; c++) begin
            if (c == 10) start8 = 1'b0;
            @(negedge clk);
            if (done8) dq.push_back(c);
            if (c == 9) begin
                vectors++; if (bcd8 !== 12'h100) begin miscompares++; $display("FAIL b2b_first: got %h want 100", bcd8); end
            end
            if (c >= 10 && c <= 17 && bcd8 !== 12'h100) hold_ok = 1'b0;
            if (c == 18) begin
                vectors++; if (bcd8 !== 12'h200) begin miscompares++; $display("FAIL b2b_second: got %h want 200", bcd8); end
            end
            tick();
        end
        vectors++; if (!hold_ok) begin miscompares++; $display("FAIL b2b_hold: bcd_out changed between pulses"); end
        vectors++;
        if (dq.size() != 2 || dq[0] != 9 || dq[1] != 18) begin
            miscompares++;
            $display("FAIL b2b_done_cycles: got %0d pulses (first %0d) want cycles 9 and 18", dq.size(), dq.size() > 0 ? dq[0] : -1);
        end
    endtask

    task automatic test_start_ignored();
        int dq[$];
        logic [11:0] at_done = '0;
        start8 = 1'b1; bin8 = 8'd37;
        tick();
        for (int c = 1; c <= 25; c++) begin
            start8 = (c == 4);
            bin8   = (c == 4) ? 8'd250 : 8'($urandom);
            @(negedge clk);
            if (done8) begin dq.push_back(c); at_done = bcd8; end
            tick();
        end
        start8 = 1'b0;
        vectors++;
        if (dq.size() != 1 || dq[0] != 9) begin
            miscompares++;
            $display("FAIL ignored_done_cycles: got %0d pulses want one at cycle 9", dq.size());
        end
        vectors++; if (at_done !== 12'h037) begin miscompares++; $display("FAIL ignored_result: got %h want 037", at_done); end
    endtask

    task automatic test_sweep();
        int perm[256];
        int cyc; logic [19:0] res; bit bok;
        int tmp, j;
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            run_conv(1'b0, perm[i], 1'b1, cyc, res, bok);
            vectors++;
            if (res !== ref_bcd(perm[i]) || cyc !== 9 || !bok) begin
                miscompares++;
                $display("FAIL sweep_%0d: got %h at cycle %0d busy_ok %0d want %h at cycle 9", perm[i], res[11:0], cyc, bok, ref_bcd(perm[i]));
            end
            tick();
        end
    endtask

    task automatic test_wide();
        int cyc; logic [19:0] res; bit bok;
        int unsigned v;
        run_conv(1'b1, 65535, 1'b1, cyc, res, bok);
        vectors++; if (cyc !== 17)        begin miscompares++; $display("FAIL latency16: done cycle %0d want 17", cyc); end
        vectors++; if (res !== 20'h65535) begin miscompares++; $display("FAIL max16: got %h want 65535", res); end
        vectors++; if (bok !== 1'b1)      begin miscompares++; $display("FAIL busy_window16: busy not high exactly in cycles 1..16"); end
        tick();
        for (int i = 0; i < 20; i++) begin
            v = $urandom_range(65535, 0);
            run_conv(1'b1, v, 1'b1, cyc, res, bok);
            vectors++;
            if (res !== ref_bcd(v) || cyc !== 17) begin
                miscompares++;
                $display("FAIL rand16_%0d: got %h at cycle %0d want %h at cycle 17", v, res, cyc, ref_bcd(v));
            end
            tick();
        end
    endtask

    task automatic test_reset_abort();
        bit quiet = 1'b1;
        bit started = 1'b0;
        start8 = 1'b1; bin8 = 8'd200;
        tick();
        start8 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            rst = (c == 5);
            @(negedge clk);
            if (c == 3) started = busy8;
            if (c >= 6 && (busy8 !== 1'b0 || done8 !== 1'b0 || bcd8 !== 12'h000)) quiet = 1'b0;
            tick();
        end
        rst = 1'b0;
        vectors++; if (started !== 1'b1) begin miscompares++; $display("FAIL abort_started: busy %b in cycle 3 want 1", started); end
        vectors++; if (!quiet) begin miscompares++; $display("FAIL abort_quiet: busy/done/bcd_out not all 0 after reset, bcd_out now %h", bcd8); end
    endtask

    initial begin
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0; bin8 = '0; bin16 = '0;
        tick();
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_start_ignored();
        test_sweep();
        test_wide();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
